// File: rtl/dmem_lsu_bridge.sv
// Bridges a single-outstanding CPU load/store port onto a request/response data-memory bus.
// Optional macro DMEM_LSU_TIMEOUT_EN adds a 255-cycle bus timeout that completes with lsu_err.
module dmem_lsu_bridge #(
  parameter int unsigned p_ADDR_BITS = 32,
  parameter int unsigned p_DATA_BITS = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lsu_valid,
  input  logic                   lsu_we,
  input  logic [1:0]             lsu_size,
  input  logic                   lsu_unsigned,
  input  logic [p_ADDR_BITS-1:0] lsu_addr,
  input  logic [p_DATA_BITS-1:0] lsu_wdata,
  output logic                   lsu_ready,
  output logic                   lsu_done,
  output logic [p_DATA_BITS-1:0] lsu_rdata,
  output logic                   lsu_misalign,
  output logic                   lsu_err,
  output logic [p_ADDR_BITS-1:0] dmem_addr,
  output logic                   dmem_cmd,
  output logic [1:0]             dmem_size,
  output logic                   dmem_valid,
  output logic                   dmem_r_ready,
  output logic                   dmem_w_valid,
  output logic [3:0]             dmem_w_strb,
  output logic [p_DATA_BITS-1:0] dmem_w_data,
  input  logic                   dmem_ready,
  input  logic                   dmem_r_valid,
  input  logic [p_DATA_BITS-1:0] dmem_r_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RWAIT,
    S_RESP
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;

  logic [p_ADDR_BITS-1:0]   r_addr;
  logic                     r_we;
  logic [1:0]               r_size;
  logic                     r_unsigned;
  logic [p_DATA_BITS-1:0]   r_wdata;
  logic [p_DATA_BITS-1:0]   r_rdata;
  logic                     r_misalign;

  logic                     w_accept;
  logic                     w_misalign;
  logic                     w_timeout;
  logic                     w_abort;
  logic                     w_enter_resp;
  logic [7:0]               w_byte;
  logic [15:0]              w_half;
  logic [p_DATA_BITS-1:0]   w_load_data;
  logic [p_DATA_BITS-1:0]   w_resp_data;
  logic [3:0]               w_strb;
  logic [p_DATA_BITS-1:0]   w_store_data;

  assign w_accept = lsu_valid && (r_state == S_IDLE);

  always_comb begin
    w_misalign = 1'b0;
    case (lsu_size)
      2'd0:    w_misalign = 1'b0;
      2'd1:    w_misalign = lsu_addr[0];
      2'd2:    w_misalign = |lsu_addr[1:0];
      default: w_misalign = 1'b1;
    endcase
  end

`ifdef DMEM_LSU_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_err;

  // Abort on the edge where the count would reach 255, so done lands 255 cycles after REQ entry.
  assign w_timeout = (r_cnt == 8'hFE);
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (lsu_valid) begin
          w_state_nxt = w_misalign ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (dmem_ready) begin
          w_state_nxt = r_we ? S_RESP : S_RWAIT;
        end else if (w_timeout) begin
          w_state_nxt = S_RESP;
          w_abort     = 1'b1;
        end
      end
      S_RWAIT: begin
        if (dmem_r_valid) begin
          w_state_nxt = S_RESP;
        end else if (w_timeout) begin
          w_state_nxt = S_RESP;
          w_abort     = 1'b1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_enter_resp = (r_state != S_RESP) && (w_state_nxt == S_RESP);

  always_comb begin
    w_byte = dmem_r_data[7:0];
    case (r_addr[1:0])
      2'd0:    w_byte = dmem_r_data[7:0];
      2'd1:    w_byte = dmem_r_data[15:8];
      2'd2:    w_byte = dmem_r_data[23:16];
      default: w_byte = dmem_r_data[31:24];
    endcase
    w_half = r_addr[1] ? dmem_r_data[31:16] : dmem_r_data[15:0];

    w_load_data = dmem_r_data;
    case (r_size)
      2'd0:    w_load_data = {{24{~r_unsigned & w_byte[7]}}, w_byte};
      2'd1:    w_load_data = {{16{~r_unsigned & w_half[15]}}, w_half};
      default: w_load_data = dmem_r_data;
    endcase
  end

  // Only a completed read returns data; stores, misaligns and timeouts report zero.
  assign w_resp_data = (r_state == S_RWAIT && dmem_r_valid) ? w_load_data : '0;

  always_comb begin
    w_strb       = 4'b1111;
    w_store_data = r_wdata;
    case (r_size)
      2'd0: begin
        w_strb       = 4'b0001 << r_addr[1:0];
        w_store_data = {4{r_wdata[7:0]}};
      end
      2'd1: begin
        w_strb       = 4'b0011 << r_addr[1:0];
        w_store_data = {2{r_wdata[15:0]}};
      end
      default: begin
        w_strb       = 4'b1111;
        w_store_data = r_wdata;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_misalign <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr     <= lsu_addr;
        r_we       <= lsu_we;
        r_size     <= lsu_size;
        r_unsigned <= lsu_unsigned;
        r_wdata    <= lsu_wdata;
        r_misalign <= w_misalign;
      end
      if (w_enter_resp) begin
        r_rdata <= w_resp_data;
      end
    end
  end

`ifdef DMEM_LSU_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_accept && !w_misalign) begin
        r_cnt <= '0;
      end else if (r_state == S_REQ || r_state == S_RWAIT) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_enter_resp) begin
        r_err <= w_abort;
      end
    end
  end

  assign lsu_err = (r_state == S_RESP) && r_err;
`else
  assign lsu_err = 1'b0;
`endif

  assign lsu_ready    = rst && (r_state == S_IDLE);
  assign lsu_done     = (r_state == S_RESP);
  assign lsu_rdata    = r_rdata;
  assign lsu_misalign = (r_state == S_RESP) && r_misalign;

  assign dmem_addr    = r_addr;
  assign dmem_cmd     = r_we;
  assign dmem_size    = r_size;
  assign dmem_valid   = (r_state == S_REQ);
  assign dmem_w_valid = (r_state == S_REQ) && r_we;
  assign dmem_r_ready = (r_state == S_RWAIT);
  assign dmem_w_strb  = dmem_w_valid ? w_strb : 4'b0000;
  assign dmem_w_data  = dmem_w_valid ? w_store_data : '0;

endmodule

// File: tb/tb_dmem_lsu_bridge.sv
// Directed, table-driven bench for dmem_lsu_bridge; timeout case runs only with DMEM_LSU_TIMEOUT_EN.
module tb_dmem_lsu_bridge;

  logic        clk;
  logic        rst;
  logic        lsu_valid;
  logic        lsu_we;
  logic [1:0]  lsu_size;
  logic        lsu_unsigned;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_ready;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic        lsu_misalign;
  logic        lsu_err;
  logic [31:0] dmem_addr;
  logic        dmem_cmd;
  logic [1:0]  dmem_size;
  logic        dmem_valid;
  logic        dmem_r_ready;
  logic        dmem_w_valid;
  logic [3:0]  dmem_w_strb;
  logic [31:0] dmem_w_data;
  logic        dmem_ready;
  logic        dmem_r_valid;
  logic [31:0] dmem_r_data;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  dmem_lsu_bridge #(.p_ADDR_BITS(32), .p_DATA_BITS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .lsu_valid    (lsu_valid),
    .lsu_we       (lsu_we),
    .lsu_size     (lsu_size),
    .lsu_unsigned (lsu_unsigned),
    .lsu_addr     (lsu_addr),
    .lsu_wdata    (lsu_wdata),
    .lsu_ready    (lsu_ready),
    .lsu_done     (lsu_done),
    .lsu_rdata    (lsu_rdata),
    .lsu_misalign (lsu_misalign),
    .lsu_err      (lsu_err),
    .dmem_addr    (dmem_addr),
    .dmem_cmd     (dmem_cmd),
    .dmem_size    (dmem_size),
    .dmem_valid   (dmem_valid),
    .dmem_r_ready (dmem_r_ready),
    .dmem_w_valid (dmem_w_valid),
    .dmem_w_strb  (dmem_w_strb),
    .dmem_w_data  (dmem_w_data),
    .dmem_ready   (dmem_ready),
    .dmem_r_valid (dmem_r_valid),
    .dmem_r_data  (dmem_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdin;
    int unsigned rdly;
    int unsigned vdly;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    chk({tag, " ready_idle"}, {31'd0, lsu_ready}, 32'd1);
    lsu_valid    = 1'b1;
    lsu_we       = v.we;
    lsu_size     = v.size;
    lsu_unsigned = v.uns;
    lsu_addr     = v.addr;
    lsu_wdata    = v.wdata;
    step();
    lsu_valid    = 1'b0;
    lsu_we       = 1'b0;
    lsu_wdata    = 32'h0;
    if (v.exp_mis) begin
      chk({tag, " mis_done"},     {31'd0, lsu_done},     32'd1);
      chk({tag, " mis_flag"},     {31'd0, lsu_misalign}, 32'd1);
      chk({tag, " mis_rdata"},    lsu_rdata,             32'd0);
      chk({tag, " mis_no_valid"}, {31'd0, dmem_valid},   32'd0);
      chk({tag, " mis_err"},      {31'd0, lsu_err},      32'd0);
      step();
      chk({tag, " mis_done_low"}, {31'd0, lsu_done},     32'd0);
      chk({tag, " mis_flag_low"}, {31'd0, lsu_misalign}, 32'd0);
      chk({tag, " mis_no_valid2"},{31'd0, dmem_valid},   32'd0);
    end else begin
      for (int unsigned c = 0; c <= v.rdly; c++) begin
        chk({tag, " req_valid"},  {31'd0, dmem_valid},   32'd1);
        chk({tag, " req_addr"},   dmem_addr,             v.addr);
        chk({tag, " req_cmd"},    {31'd0, dmem_cmd},     {31'd0, v.we});
        chk({tag, " req_size"},   {30'd0, dmem_size},    {30'd0, v.size});
        chk({tag, " req_rready"}, {31'd0, dmem_r_ready}, 32'd0);
        chk({tag, " req_done"},   {31'd0, lsu_done},     32'd0);
        chk({tag, " req_wvalid"}, {31'd0, dmem_w_valid}, {31'd0, v.we});
        if (v.we) begin
          chk({tag, " req_strb"},  {28'd0, dmem_w_strb}, {28'd0, v.exp_strb});
          chk({tag, " req_wdata"}, dmem_w_data,          v.exp_wdata);
        end
        dmem_ready = (c == v.rdly);
        step();
        dmem_ready = 1'b0;
      end
      if (!v.we) begin
        for (int unsigned c = 0; c <= v.vdly; c++) begin
          chk({tag, " rw_valid"},  {31'd0, dmem_valid},   32'd0);
          chk({tag, " rw_rready"}, {31'd0, dmem_r_ready}, 32'd1);
          chk({tag, " rw_done"},   {31'd0, lsu_done},     32'd0);
          dmem_r_valid = (c == v.vdly);
          dmem_r_data  = (c == v.vdly) ? v.rdin : 32'h5A5A_A5A5;
          step();
          dmem_r_valid = 1'b0;
          dmem_r_data  = 32'h0;
        end
      end
      chk({tag, " done"},        {31'd0, lsu_done},     32'd1);
      chk({tag, " done_mis"},    {31'd0, lsu_misalign}, 32'd0);
      chk({tag, " done_err"},    {31'd0, lsu_err},      32'd0);
      chk({tag, " done_dvalid"}, {31'd0, dmem_valid},   32'd0);
      chk({tag, " done_wvalid"}, {31'd0, dmem_w_valid}, 32'd0);
      chk({tag, " done_rready"}, {31'd0, dmem_r_ready}, 32'd0);
      chk({tag, " done_ready"},  {31'd0, lsu_ready},    32'd0);
      if (!v.we) chk({tag, " rdata"}, lsu_rdata, v.exp_rdata);
      step();
      chk({tag, " done_pulse"},  {31'd0, lsu_done},     32'd0);
      chk({tag, " ready_back"},  {31'd0, lsu_ready},    32'd1);
      if (!v.we) chk({tag, " rdata_hold"}, lsu_rdata, v.exp_rdata);
    end
  endtask

  initial begin
    vec_t vr;
    logic [31:0] held;

    //                we    sz    uns   addr          wdata         rdin          rd vd exp_rdata     strb     exp_wdata     mis
    vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0,        32'h80AA_BBCC, 0, 0, 32'hFFFF_FF80, 4'b0000, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0102, 32'h0,        32'h80AA_BBCC, 1, 0, 32'h0000_00AA, 4'b0000, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0101, 32'h0,        32'h80AA_BBCC, 0, 2, 32'hFFFF_FFBB, 4'b0000, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0100, 32'h0,        32'h1234_5678, 0, 0, 32'h0000_0078, 4'b0000, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0202, 32'h0,        32'h80AA_BBCC, 2, 1, 32'hFFFF_80AA, 4'b0000, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0200, 32'h0,        32'h80AA_BBCC, 0, 0, 32'h0000_BBCC, 4'b0000, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0200, 32'h0,        32'h80AA_BBCC, 0, 0, 32'hFFFF_BBCC, 4'b0000, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0,        32'h80AA_BBCC, 1, 1, 32'h80AA_BBCC, 4'b0000, 32'h0,        1'b0};
    vecs[8]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0401, 32'h1234_ABCD, 32'h0,        0, 0, 32'h0,        4'b0010, 32'hCDCD_CDCD, 1'b0};
    vecs[9]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        0, 0, 32'h0,        4'b1100, 32'hABCD_ABCD, 1'b0};
    vecs[10] = '{1'b1, 2'd1, 1'b0, 32'h0000_0200, 32'h1234_ABCD, 32'h0,        2, 0, 32'h0,        4'b0011, 32'hABCD_ABCD, 1'b0};
    vecs[11] = '{1'b1, 2'd2, 1'b0, 32'h0000_0500, 32'hDEAD_BEEF, 32'h0,        1, 0, 32'h0,        4'b1111, 32'hDEAD_BEEF, 1'b0};
    vecs[12] = '{1'b1, 2'd0, 1'b0, 32'h0000_0403, 32'h0000_005A, 32'h0,        0, 0, 32'h0,        4'b1000, 32'h5A5A_5A5A, 1'b0};
    vecs[13] = '{1'b0, 2'd2, 1'b0, 32'h0000_0301, 32'h0,        32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        1'b1};
    vecs[14] = '{1'b0, 2'd1, 1'b0, 32'h0000_0203, 32'h0,        32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        1'b1};
    vecs[15] = '{1'b0, 2'd3, 1'b0, 32'h0000_0400, 32'h0,        32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        1'b1};
    vecs[16] = '{1'b1, 2'd2, 1'b0, 32'h0000_0502, 32'hCAFE_F00D, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        1'b1};

    rst          = 1'b0;
    lsu_valid    = 1'b0;
    lsu_we       = 1'b0;
    lsu_size     = 2'd0;
    lsu_unsigned = 1'b0;
    lsu_addr     = 32'h0;
    lsu_wdata    = 32'h0;
    dmem_ready   = 1'b0;
    dmem_r_valid = 1'b0;
    dmem_r_data  = 32'h0;
    repeat (3) step();

    chk("rst lsu_ready", {31'd0, lsu_ready},    32'd0);
    chk("rst lsu_done",  {31'd0, lsu_done},     32'd0);
    chk("rst dvalid",    {31'd0, dmem_valid},   32'd0);
    chk("rst rdata",     lsu_rdata,             32'd0);
    chk("rst strb",      {28'd0, dmem_w_strb},  32'd0);
    chk("rst wdata",     dmem_w_data,           32'd0);
    chk("rst addr",      dmem_addr,             32'd0);
    rst = 1'b1;
    #1;
    chk("rst release ready", {31'd0, lsu_ready}, 32'd1);
    step();

    dmem_r_valid = 1'b1;
    dmem_r_data  = 32'hFFFF_FFFF;
    step();
    dmem_r_valid = 1'b0;
    dmem_r_data  = 32'h0;
    chk("idle rvalid done",  {31'd0, lsu_done},  32'd0);
    chk("idle rvalid ready", {31'd0, lsu_ready}, 32'd1);
    chk("idle rvalid rdata", lsu_rdata,          32'd0);

    for (int i = 0; i < 17; i++) begin
      run_txn(vecs[i], $sformatf("v%0d", i));
    end

    // Slow bus: dmem_ready low for 5 cycles, read data 3 cycles late.
    vr = '{1'b0, 2'd2, 1'b0, 32'h0000_0600, 32'h0, 32'h0BAD_CAFE, 5, 3, 32'h0BAD_CAFE, 4'b0000, 32'h0, 1'b0};
    run_txn(vr, "slow");

    held = lsu_rdata;
    lsu_valid = 1'b1;
    lsu_we    = 1'b0;
    lsu_size  = 2'd1;
    lsu_addr  = 32'h0000_0702;
    step();
    lsu_valid = 1'b0;
    dmem_ready = 1'b1;
    step();
    dmem_ready = 1'b0;
    chk("rstmid rwait", {31'd0, dmem_r_ready}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid rready", {31'd0, dmem_r_ready}, 32'd0);
    chk("rstmid dvalid", {31'd0, dmem_valid},   32'd0);
    chk("rstmid ready",  {31'd0, lsu_ready},    32'd0);
    chk("rstmid done",   {31'd0, lsu_done},     32'd0);
    chk("rstmid addr",   dmem_addr,             32'd0);
    chk("rstmid size",   {30'd0, dmem_size},    32'd0);
    chk("rstmid rdata",  lsu_rdata,             32'd0);
    chk("rstmid prior",  held,                  32'h0BAD_CAFE);
    dmem_r_valid = 1'b1;
    dmem_r_data  = 32'h1111_2222;
    step();
    rst = 1'b1;
    step();
    dmem_r_valid = 1'b0;
    dmem_r_data  = 32'h0;
    chk("rstmid post ready", {31'd0, lsu_ready},  32'd1);
    chk("rstmid post done",  {31'd0, lsu_done},   32'd0);
    chk("rstmid post dvalid",{31'd0, dmem_valid}, 32'd0);
    run_txn(vecs[4], "after_rst");

`ifdef DMEM_LSU_TIMEOUT_EN
    begin
      int unsigned n;
      lsu_valid = 1'b1;
      lsu_we    = 1'b1;
      lsu_size  = 2'd2;
      lsu_addr  = 32'h0000_0800;
      lsu_wdata = 32'h1234_5678;
      step();
      lsu_valid = 1'b0;
      n = 0;
      while (!lsu_done && n < 400) begin
        step();
        n++;
      end
      chk("tmo cycles", n,                      32'd255);
      chk("tmo done",   {31'd0, lsu_done},      32'd1);
      chk("tmo err",    {31'd0, lsu_err},       32'd1);
      chk("tmo rdata",  lsu_rdata,              32'd0);
      step();
      chk("tmo err_low", {31'd0, lsu_err},      32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_lsu_bridge.md
DMEM_LSU_BRIDGE -- requirements
Module: dmem_lsu_bridge

Interface
REQ-001 SHALL have parameter p_ADDR_BITS, default 32, meaning the byte address width.
REQ-002 SHALL have parameter p_DATA_BITS, default 32, meaning the data width; only 32 is supported.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have CPU-side inputs lsu_valid (1), lsu_we (1, 1=store), lsu_size (2: 0=byte, 1=half, 2=word), lsu_unsigned (1), lsu_addr (p_ADDR_BITS) and lsu_wdata (32).
REQ-006 SHALL have CPU-side outputs lsu_ready (1), lsu_done (1, one-cycle completion pulse), lsu_rdata (32), lsu_misalign (1) and lsu_err (1).
REQ-007 SHALL have dmem-side outputs dmem_addr (p_ADDR_BITS), dmem_cmd (1, 1=write), dmem_size (2), dmem_valid (1), dmem_r_ready (1), dmem_w_valid (1), dmem_w_strb (4) and dmem_w_data (32).
REQ-008 SHALL have dmem-side inputs dmem_ready (1), dmem_r_valid (1) and dmem_r_data (32, full aligned word).

Function
REQ-009 SHALL implement FSM states IDLE, REQ, RWAIT and RESP.
REQ-010 SHALL drive lsu_ready=1 only in IDLE; a request is accepted when lsu_valid&&lsu_ready, which registers addr/we/size/unsigned/wdata.
REQ-011 SHALL treat as misaligned: half with addr[0]=1, word with addr[1:0]!=0, and size=3; accept->RESP with no dmem access, lsu_misalign=1, lsu_rdata=0.
REQ-012 SHALL, for an aligned accept, go IDLE->REQ, and in REQ hold dmem_valid=1 with registered dmem_addr (unmodified byte address), dmem_cmd=we and dmem_size=size until dmem_valid&&dmem_ready.
REQ-013 SHALL, for a store in REQ, assert dmem_w_valid=1 together with dmem_valid and take REQ->RESP on dmem_ready.
REQ-014 SHALL generate the store strobe as: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-015 SHALL generate store data as: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-016 SHALL, for a load, take REQ->RWAIT on handshake, then hold dmem_r_ready=1 in RWAIT until dmem_r_valid, then capture data and go RWAIT->RESP.
REQ-017 SHALL extract load data by byte lane addr[1:0] (byte) or addr[1] (half), zero-extending if unsigned and sign-extending otherwise; word loads pass through unchanged.
REQ-018 SHALL, in RESP, assert lsu_done=1 for exactly one cycle with lsu_rdata/lsu_misalign/lsu_err valid, then go to IDLE; accept-to-done latency is 1 (misalign), >=2 (store) and >=3 (load).
REQ-019 SHALL deassert dmem_valid, dmem_w_valid and dmem_r_ready in IDLE/RESP, and deassert dmem_w_valid for loads.
REQ-020 SHALL hold lsu_rdata until the next lsu_done; lsu_misalign/lsu_err are 0 outside lsu_done.
REQ-021 SHALL ignore dmem_r_valid outside RWAIT, and ignore lsu_valid outside IDLE (no queuing).

Reset
REQ-022 SHALL, on rst low at any time, including mid-transaction, go immediately to IDLE with every output 0, except lsu_ready=1 once rst is high.
REQ-023 SHALL NOT hold or retry an in-flight bus transaction after reset; the transaction is dropped.

Configuration
REQ-024 SHALL, with macro DMEM_LSU_TIMEOUT_EN defined, run an 8-bit counter that clears on entering REQ and increments each cycle in REQ/RWAIT.
REQ-025 SHALL, with DMEM_LSU_TIMEOUT_EN defined, when the counter reaches 255, abort to RESP with lsu_err=1 and lsu_rdata=0.
REQ-026 SHALL, without DMEM_LSU_TIMEOUT_EN, contain no counter, tie lsu_err to 0 and wait indefinitely.

Verification
REQ-027 SHALL cover: signed byte load addr=0x103, dmem_r_data=0x80AABBCC -> dmem_addr=0x103, lsu_rdata=0xFFFFFF80, one lsu_done pulse.
REQ-028 SHALL cover: half store addr=0x202, wdata=0x1234ABCD -> dmem_w_strb=4'b1100, dmem_w_data=0xABCDABCD, dmem_cmd=1, lsu_done 1 cycle after dmem_ready.
REQ-029 SHALL cover: word load addr=0x301 -> no dmem_valid, lsu_done+lsu_misalign=1 on the next cycle, lsu_rdata=0.
REQ-030 SHALL cover: load with dmem_ready held low 5 cycles, then dmem_r_valid delayed 3 cycles -> dmem_valid stable throughout, dmem_r_ready=1 only in RWAIT, single lsu_done.
REQ-031 SHALL cover: rst low while in RWAIT -> all outputs 0 asynchronously; a new request after release completes normally.
REQ-032 SHALL cover, with DMEM_LSU_TIMEOUT_EN: dmem_ready never asserted -> lsu_done+lsu_err=1 at 255 cycles after entering REQ.
